// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory masters (C and D), the arbiter and the memory macro.
// slave = arbiter side; master = requesters plus memory model side.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: CPU port C has fixed priority, debug port D gets forced
// priority after MAX_WAIT consecutive lost decisions. One access in flight at a time.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    dmem_port_arbiter_if.slave  bus
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;  // 1 = port D owns the access
    logic [3:0]        d_wait_q, d_wait_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              c_gnt_q, c_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              c_rvalid_q, c_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;

    logic any_req;
    logic d_wins;

    assign any_req = bus.c_req | bus.d_req;
    assign d_wins  = bus.d_req & (~bus.c_req | (d_wait_q >= MaxWait));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StIssue;
            StIssue:  state_d = mem_we_q ? StIdle : StRdWait;
            StRdWait: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        owner_d     = owner_q;
        d_wait_d    = d_wait_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        c_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        c_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        c_rdata_d   = c_rdata_q;
        d_rdata_d   = d_rdata_q;
        busy_d      = (state_d != StIdle);

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d  = d_wins;
                    mem_en_d = 1'b1;
                    if (d_wins) begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        d_gnt_d     = 1'b1;
                    end else begin
                        mem_we_d    = bus.c_we;
                        mem_addr_d  = bus.c_addr;
                        mem_wdata_d = bus.c_wdata;
                        c_gnt_d     = 1'b1;
                    end
                end
                if (bus.d_req && !d_wins) begin
                    d_wait_d = (d_wait_q == 4'hF) ? 4'hF : d_wait_q + 4'd1;
                end else begin
                    d_wait_d = 4'd0;
                end
            end
            StIssue: begin
                if (!mem_we_q) begin
                    if (owner_q) d_rvalid_d = 1'b1;
                    else         c_rvalid_d = 1'b1;
                end
            end
            StRdWait: begin
                if (owner_q) d_rdata_d = bus.mem_rdata;
                else         c_rdata_d = bus.mem_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= 1'b0;
            d_wait_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            c_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            c_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            d_wait_q    <= d_wait_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            c_gnt_q     <= c_gnt_d;
            d_gnt_q     <= d_gnt_d;
            c_rvalid_q  <= c_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.c_gnt     = c_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.c_rvalid  = c_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.busy      = busy_q;

    // The macro's output register is the source during the rvalid cycle, so read data lines up
    // with rvalid; the held copy takes over from the next cycle on.
    assign bus.c_rdata = c_rvalid_q ? bus.mem_rdata : c_rdata_q;
    assign bus.d_rdata = d_rvalid_q ? bus.mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (winner choice, latency, shadow memory, read data).
module tb_dmem_port_arbiter;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory macro
    logic [DATA_W-1:0] mem [16];
    always_ff @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit pd, input logic req, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dat);
        if (pd) begin
            bus.d_req = req; bus.d_we = we; bus.d_addr = a; bus.d_wdata = dat;
        end else begin
            bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = dat;
        end
    endtask

    // Write through the arbiter; returns with the arbiter idle and the request dropped.
    task automatic do_write(input bit pd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dat);
        bit got;
        got = 1'b0;
        drive(pd, 1'b1, 1'b1, a, dat);
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = pd ? bus.d_gnt : bus.c_gnt;
        end
        drive(pd, 1'b0, 1'b0, a, dat);
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL write_grant_timeout port_d=%0d addr=%0d: got gnt=0 expected gnt=1", pd, a);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        checks++;
        if ({bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we, bus.busy}
            !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {bus.c_gnt, bus.d_gnt,
                     bus.c_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we, bus.busy});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.c_rdata, bus.d_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h wdata=%h crd=%h drd=%h expected all 0",
                     bus.mem_addr, bus.mem_wdata, bus.c_rdata, bus.d_rdata);
        end
        checks++;
        if (dut.d_wait_q !== 4'd0) begin
            fails++;
            $display("FAIL reset_d_wait: got %0d expected 0", dut.d_wait_q);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_c_read();
        do_write(1'b0, 4'd3, 32'hDEADBEEF);
        do_write(1'b1, 4'd7, 32'h0000_0077);
        drive(1'b0, 1'b1, 1'b0, 4'd3, '0);
        tick();
        checks++;
        if ({bus.c_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.busy, bus.c_rvalid} !== 6'b101010
            || bus.mem_addr !== 4'd3) begin
            fails++;
            $display("FAIL c_read_issue: got cgnt/dgnt/en/we/busy/rv=%b addr=%0d expected 101010 addr=3",
                     {bus.c_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.busy, bus.c_rvalid},
                     bus.mem_addr);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd3, '0);
        tick();
        checks++;
        if ({bus.c_rvalid, bus.busy, bus.c_gnt, bus.mem_en} !== 4'b1100
            || bus.c_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL c_read_rvalid: got rv/busy/gnt/en=%b rdata=%h expected 1100 DEADBEEF",
                     {bus.c_rvalid, bus.busy, bus.c_gnt, bus.mem_en}, bus.c_rdata);
        end
        tick();
        checks++;
        if ({bus.c_rvalid, bus.busy} !== 2'b00 || bus.c_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL c_read_after: got rv/busy=%b rdata=%h expected 00 DEADBEEF",
                     {bus.c_rvalid, bus.busy}, bus.c_rdata);
        end
    endtask

    task automatic test_collision();
        drive(1'b0, 1'b1, 1'b1, 4'd5, 32'h12);
        drive(1'b1, 1'b1, 1'b0, 4'd5, '0);
        tick();
        checks++;
        if ({bus.c_gnt, bus.d_gnt, bus.mem_we} !== 3'b101 || bus.mem_addr !== 4'd5
            || bus.mem_wdata !== 32'h12) begin
            fails++;
            $display("FAIL collision_c_first: got cgnt/dgnt/we=%b addr=%0d wdata=%h expected 101 5 12",
                     {bus.c_gnt, bus.d_gnt, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (dut.d_wait_q !== 4'd1) begin
            fails++;
            $display("FAIL collision_d_wait_one: got %0d expected 1", dut.d_wait_q);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd5, '0);
        tick();
        checks++;
        if ({bus.c_gnt, bus.d_gnt, bus.busy} !== 3'b000) begin
            fails++;
            $display("FAIL collision_idle: got %b expected 000", {bus.c_gnt, bus.d_gnt, bus.busy});
        end
        tick();
        checks++;
        if ({bus.c_gnt, bus.d_gnt, bus.mem_we} !== 3'b010 || bus.mem_addr !== 4'd5
            || dut.d_wait_q !== 4'd0) begin
            fails++;
            $display("FAIL collision_d_grant: got cgnt/dgnt/we=%b addr=%0d wait=%0d expected 010 5 0",
                     {bus.c_gnt, bus.d_gnt, bus.mem_we}, bus.mem_addr, dut.d_wait_q);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd5, '0);
        tick();
        checks++;
        if ({bus.d_rvalid, bus.c_rvalid} !== 2'b10 || bus.d_rdata !== 32'h12) begin
            fails++;
            $display("FAIL collision_d_data: got drv/crv=%b drdata=%h expected 10 00000012",
                     {bus.d_rvalid, bus.c_rvalid}, bus.d_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        int  losses;
        bit  d_won;
        losses = 0;
        d_won  = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'd7, '0);
        drive(1'b0, 1'b1, 1'b1, 4'd8, 32'd0);
        for (int n = 1; n < 40 && !d_won; n++) begin
            tick();
            if (bus.d_gnt) begin
                d_won = 1'b1;
                checks++;
                if (bus.c_gnt !== 1'b0) begin
                    fails++;
                    $display("FAIL starve_exclusive: got c_gnt=1 expected 0 during D grant");
                end
            end else if (bus.c_gnt) begin
                losses++;
                drive(1'b0, 1'b1, 1'b1, 4'(8 + (n % 4)), 32'(n));
            end
        end
        checks++;
        if (!d_won || losses != MAX_WAIT) begin
            fails++;
            $display("FAIL starve_losses: got won=%0d losses=%0d expected won=1 losses=%0d",
                     d_won, losses, MAX_WAIT);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd7, '0);
        tick();
        checks++;
        if (bus.c_gnt !== 1'b0 || bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h77) begin
            fails++;
            $display("FAIL starve_d_read: got cgnt=%b drv=%b drdata=%h expected 0 1 00000077",
                     bus.c_gnt, bus.d_rvalid, bus.d_rdata);
        end
        tick();
        checks++;
        if (bus.c_gnt !== 1'b0) begin
            fails++;
            $display("FAIL starve_idle_gap: got c_gnt=%b expected 0", bus.c_gnt);
        end
        tick();
        checks++;
        if (bus.c_gnt !== 1'b1) begin
            fails++;
            $display("FAIL starve_c_resume: got c_gnt=%b expected 1", bus.c_gnt);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_d_write_c_read();
        bit d_rv_seen;
        d_rv_seen = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 4'd0, 32'h5);
        tick();
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 4'd0) begin
            fails++;
            $display("FAIL dwrite_grant: got dgnt=%b we=%b addr=%0d expected 1 1 0",
                     bus.d_gnt, bus.mem_we, bus.mem_addr);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, '0);
        drive(1'b0, 1'b1, 1'b0, 4'd0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            d_rv_seen |= bus.d_rvalid;
            if (bus.c_gnt) drive(1'b0, 1'b0, 1'b0, 4'd0, '0);
            if (bus.c_rvalid) begin
                checks++;
                if (bus.c_rdata !== 32'h5 || bus.d_rdata !== 32'h77) begin
                    fails++;
                    $display("FAIL dwrite_c_read: got crdata=%h drdata=%h expected 00000005 00000077",
                             bus.c_rdata, bus.d_rdata);
                end
            end
        end
        checks++;
        if (d_rv_seen || bus.c_rdata !== 32'h5) begin
            fails++;
            $display("FAIL dwrite_no_drvalid: got d_rvalid_seen=%0d crdata=%h expected 0 00000005",
                     d_rv_seen, bus.c_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, 1'b1, 1'b0, 4'd3, '0);
        tick();
        checks++;
        if (bus.c_gnt !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_issue: got c_gnt=%b expected 1", bus.c_gnt);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd3, '0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.c_rvalid, bus.d_rvalid, bus.busy, bus.mem_en, bus.c_gnt} !== 5'b0
            || {bus.c_rdata, bus.d_rdata, bus.mem_addr} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got rv/rv/busy/en/gnt=%b crd=%h drd=%h addr=%h expected 0",
                     {bus.c_rvalid, bus.d_rvalid, bus.busy, bus.mem_en, bus.c_gnt},
                     bus.c_rdata, bus.d_rdata, bus.mem_addr);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.c_rvalid, bus.busy} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_release: got rv/busy=%b expected 00", {bus.c_rvalid, bus.busy});
        end
        drive(1'b0, 1'b1, 1'b0, 4'd3, '0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd3, '0);
        tick();
        checks++;
        if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rstmid_new_read: got rv=%b rdata=%h expected 1 DEADBEEF",
                     bus.c_rvalid, bus.c_rdata);
        end
        tick();
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({bus.mem_en, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid} !== 5'b0
                || bus.mem_addr !== 4'd3 || bus.c_rdata !== 32'hDEADBEEF || bus.d_rdata !== '0) begin
                fails++;
                $display("FAIL idle_hold cyc=%0d: got ctrl=%b addr=%0d crd=%h drd=%h expected 0 3 DEADBEEF 0",
                         i, {bus.mem_en, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid},
                         bus.mem_addr, bus.c_rdata, bus.d_rdata);
            end
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] shadow [16];
        logic [DATA_W-1:0] last_c, last_d, pend_data, w_wdata;
        logic [ADDR_W-1:0] s_c_addr, s_d_addr, w_addr;
        logic [DATA_W-1:0] s_c_wdata, s_d_wdata;
        logic              s_c_req, s_c_we, s_d_req, s_d_we, w_we;
        bit                exp_gnt, exp_d, exp_crv, exp_drv, pend_port;
        int                free_cycle, pend_cycle, mwait;

        for (int a = 0; a < 16; a++) begin
            shadow[a] = $urandom;
            do_write(a[0], 4'(a), shadow[a]);
        end
        tick();
        last_c = 32'hDEADBEEF;
        last_d = '0;
        {s_c_req, s_c_we, s_d_req, s_d_we} = 4'b0;
        s_c_addr = '0; s_d_addr = '0; s_c_wdata = '0; s_d_wdata = '0;
        free_cycle = 0;
        pend_cycle = -1;
        pend_port  = 1'b0;
        pend_data  = '0;
        mwait      = 0;

        for (int n = 0; n < 1500; n++) begin
            tick();
            exp_gnt = (n >= free_cycle) && (s_c_req || s_d_req);
            checks++;
            if ((bus.c_gnt | bus.d_gnt) !== exp_gnt || (bus.c_gnt & bus.d_gnt) !== 1'b0
                || bus.mem_en !== exp_gnt) begin
                fails++;
                $display("FAIL rand_gnt n=%0d: got c=%b d=%b en=%b expected gnt=%b",
                         n, bus.c_gnt, bus.d_gnt, bus.mem_en, exp_gnt);
            end
            if (exp_gnt) begin
                exp_d = s_d_req && (!s_c_req || mwait >= MAX_WAIT);
                w_we    = exp_d ? s_d_we    : s_c_we;
                w_addr  = exp_d ? s_d_addr  : s_c_addr;
                w_wdata = exp_d ? s_d_wdata : s_c_wdata;
                checks++;
                if (bus.d_gnt !== exp_d || bus.mem_we !== w_we || bus.mem_addr !== w_addr
                    || (w_we && bus.mem_wdata !== w_wdata)) begin
                    fails++;
                    $display("FAIL rand_winner n=%0d: got d=%b we=%b addr=%0d wd=%h expected d=%b we=%b addr=%0d wd=%h",
                             n, bus.d_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                             exp_d, w_we, w_addr, w_wdata);
                end
                if (exp_d)        mwait = 0;
                else if (s_d_req) mwait = (mwait < 15) ? mwait + 1 : 15;
                else              mwait = 0;
                if (w_we) begin
                    shadow[w_addr] = w_wdata;
                    free_cycle = n + 2;
                end else begin
                    free_cycle = n + 3;
                    pend_cycle = n + 1;
                    pend_port  = exp_d;
                    pend_data  = shadow[w_addr];
                end
            end
            exp_crv = (pend_cycle == n) && !pend_port;
            exp_drv = (pend_cycle == n) && pend_port;
            if (exp_crv) last_c = pend_data;
            if (exp_drv) last_d = pend_data;
            checks++;
            if (bus.c_rvalid !== exp_crv || bus.d_rvalid !== exp_drv) begin
                fails++;
                $display("FAIL rand_rvalid n=%0d: got c=%b d=%b expected c=%b d=%b",
                         n, bus.c_rvalid, bus.d_rvalid, exp_crv, exp_drv);
            end
            checks++;
            if (bus.c_rdata !== last_c || bus.d_rdata !== last_d) begin
                fails++;
                $display("FAIL rand_rdata n=%0d: got c=%h d=%h expected c=%h d=%h",
                         n, bus.c_rdata, bus.d_rdata, last_c, last_d);
            end
            checks++;
            if (bus.busy !== (exp_gnt | exp_crv | exp_drv)) begin
                fails++;
                $display("FAIL rand_busy n=%0d: got %b expected %b",
                         n, bus.busy, exp_gnt | exp_crv | exp_drv);
            end

            // Requesters: hold until granted, then drop or re-present a new access
            if (bus.c_gnt ? ($urandom_range(1, 0) == 1) : (!bus.c_req && $urandom_range(9, 0) < 4))
                drive(1'b0, 1'b1, 1'($urandom), 4'($urandom_range(15, 0)), $urandom);
            else if (bus.c_gnt)
                drive(1'b0, 1'b0, 1'b0, '0, '0);
            if (bus.d_gnt ? ($urandom_range(1, 0) == 1) : (!bus.d_req && $urandom_range(9, 0) < 4))
                drive(1'b1, 1'b1, 1'($urandom), 4'($urandom_range(15, 0)), $urandom);
            else if (bus.d_gnt)
                drive(1'b1, 1'b0, 1'b0, '0, '0);
            {s_c_req, s_c_we, s_c_addr, s_c_wdata} = {bus.c_req, bus.c_we, bus.c_addr, bus.c_wdata};
            {s_d_req, s_d_we, s_d_addr, s_d_wdata} = {bus.d_req, bus.d_we, bus.d_addr, bus.d_wdata};
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_c_read();
        test_collision();
        test_starvation();
        test_d_write_c_read();
        test_reset_mid_read();
        test_idle_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
